// File: rtl/data_mem_pkg.sv
// Shared definitions for the block-addressed data memory behind the data cache.
// Holds the controller state encoding and the default geometry/latency limits.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_ADDR_W  = 6;
  localparam int DEFAULT_BLOCK_W = 32;
  localparam int LATENCY_MAX     = 255;

endpackage

// File: rtl/mem_latency_timer.sv
// 8-bit access-latency counter: start loads 1, then counts up each edge
// until cleared; expire flags the edge on which the access commits.
module mem_latency_timer
  import data_mem_pkg::*;
#(
  parameter int LATENCY = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       i_start,
  input  logic       i_clear,
  output logic       o_expire,
  output logic [7:0] o_count
);

  logic [7:0] r_count;

  // A zero count means idle; only a running count advances.
  always_ff @(posedge CLK) begin
    if (RESET || i_clear) begin
      r_count <= 8'd0;
    end else if (i_start) begin
      r_count <= 8'd1;
    end else if (r_count != 8'd0) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expire = (r_count == 8'(LATENCY));
  assign o_count  = r_count;

endmodule

// File: rtl/data_memory.sv
// Backing store below the data cache: one whole-block read or write per
// request, committed a fixed LATENCY edges after acceptance.
module data_memory
  import data_mem_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int BLOCK_W = DEFAULT_BLOCK_W,
  parameter int LATENCY = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [ADDR_W-1:0]  ADDRESS,
  input  logic [BLOCK_W-1:0] WRITEDATA,
  output logic [BLOCK_W-1:0] READDATA,
  output logic               BUSYWAIT,
  output logic [1:0]         o_dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Handshake: the requester holds READ/WRITE high until BUSYWAIT is seen low
  // at a rising edge; BUSYWAIT rises combinationally with the request in IDLE,
  // stays high through BUSY and drops for the single DONE cycle.

  state_t               r_state;
  state_t               w_next;
  logic                 w_busy;
  logic                 w_start;
  logic                 w_clear;
  logic                 w_expire;
  logic [7:0]           w_count;
  logic                 r_is_write;
  logic [ADDR_W-1:0]    r_addr;
  logic [BLOCK_W-1:0]   r_wdata;
  logic [BLOCK_W-1:0]   r_readdata;
  logic [BLOCK_W-1:0]   r_mem [DEPTH];

  mem_latency_timer #(
    .LATENCY (LATENCY)
  ) u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_start  (w_start),
    .i_clear  (w_clear),
    .o_expire (w_expire),
    .o_count  (w_count)
  );

  // Explicit compares to 1 keep an X request from ever leaving IDLE.
  always_comb begin
    w_next  = r_state;
    w_busy  = 1'b0;
    w_start = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      IDLE: begin
        if ((READ == 1'b1) || (WRITE == 1'b1)) begin
          w_busy  = 1'b1;
          w_start = 1'b1;
          w_next  = BUSY;
        end
      end
      BUSY: begin
        w_busy = 1'b1;
        if (w_expire) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_clear = 1'b1;
        w_next  = IDLE;
      end
      default: begin
        w_clear = 1'b1;
        w_next  = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_readdata <= '0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_is_write <= (WRITE == 1'b1);
        r_addr     <= ADDRESS;
        r_wdata    <= WRITEDATA;
      end
      if ((r_state == BUSY) && w_expire) begin
        if (r_is_write) begin
          r_mem[r_addr] <= r_wdata;
        end else begin
          r_readdata <= r_mem[r_addr];
        end
      end
    end
  end

  assign BUSYWAIT    = RESET ? 1'b0 : w_busy;
  assign READDATA    = r_readdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: three instances (LATENCY 5, 1, 10) driven by tasks,
// with a reference memory model and an expected-READDATA queue.
module tb_data_memory;

  logic        CLK;
  logic        RESET;
  logic        rd   [3];
  logic        wr   [3];
  logic [5:0]  addr [3];
  logic [31:0] wd   [3];
  logic [31:0] rdat [3];
  logic        bw   [3];
  logic [1:0]  st   [3];

  int          lat [3] = '{5, 1, 10};
  logic [31:0] model_mem [3][64];
  logic [31:0] last_rd [3];
  logic [31:0] exp_q [$];
  int          checks;
  int          errors;

  data_memory #(.ADDR_W(6), .BLOCK_W(32), .LATENCY(5)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .READ(rd[0]), .WRITE(wr[0]), .ADDRESS(addr[0]),
    .WRITEDATA(wd[0]), .READDATA(rdat[0]), .BUSYWAIT(bw[0]), .o_dbg_state(st[0]));
  data_memory #(.ADDR_W(6), .BLOCK_W(32), .LATENCY(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .READ(rd[1]), .WRITE(wr[1]), .ADDRESS(addr[1]),
    .WRITEDATA(wd[1]), .READDATA(rdat[1]), .BUSYWAIT(bw[1]), .o_dbg_state(st[1]));
  data_memory #(.ADDR_W(6), .BLOCK_W(32), .LATENCY(10)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .READ(rd[2]), .WRITE(wr[2]), .ADDRESS(addr[2]),
    .WRITEDATA(wd[2]), .READDATA(rdat[2]), .BUSYWAIT(bw[2]), .o_dbg_state(st[2]));

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      last_rd[u] = 32'h0;
      for (int a = 0; a < 64; a++) model_mem[u][a] = 32'h0;
    end
    exp_q.delete();
  endtask

  // Counts consecutive mid-cycle samples with BUSYWAIT high, bounded.
  task automatic wait_busy(input int u, output int n);
    n = 0;
    while (bw[u] === 1'b1 && n < 300) begin
      n++;
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic check_done(input int u, input int n, input string name);
    logic [31:0] e;
    checks++;
    if (n !== lat[u] + 1) begin
      errors++;
      $display("FAIL %s busy_edges u%0d: got %0d exp %0d", name, u, n, lat[u] + 1);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard u%0d: got empty queue exp one entry", name, u);
    end else begin
      e = exp_q.pop_front();
      if (rdat[u] !== e) begin
        errors++;
        $display("FAIL %s readdata u%0d: got %h exp %h", name, u, rdat[u], e);
      end
    end
  endtask

  // Drive one request at a falling edge and retire it when BUSYWAIT drops.
  task automatic access(input int u, input logic r, input logic w,
                        input logic [5:0] a, input logic [31:0] d, input string name);
    int n;
    @(negedge CLK);
    rd[u] = r; wr[u] = w; addr[u] = a; wd[u] = d;
    if (w) model_mem[u][a] = d;
    else   last_rd[u] = model_mem[u][a];
    exp_q.push_back(last_rd[u]);
    #1;
    wait_busy(u, n);
    check_done(u, n, name);
    rd[u] = 1'b0; wr[u] = 1'b0;
    @(negedge CLK);
    #1;
    checks++;
    if (bw[u] !== 1'b0 || st[u] !== 2'b00) begin
      errors++;
      $display("FAIL %s idle_after u%0d: got bw=%b st=%b exp bw=0 st=00", name, u, bw[u], st[u]);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (bw[u] !== 1'b0 || rdat[u] !== 32'h0 || st[u] !== 2'b00) begin
        errors++;
        $display("FAIL reset_state u%0d: got bw=%b rd=%h st=%b exp 0/0/00", u, bw[u], rdat[u], st[u]);
      end
    end
    RESET = 1'b0;
    model_reset();
    access(0, 1'b1, 1'b0, 6'h3F, 32'h0, "reset_read3f");
  endtask

  task automatic test_write_read();
    access(0, 1'b0, 1'b1, 6'h15, 32'hDEADBEEF, "wr_15");
    access(0, 1'b1, 1'b0, 6'h15, 32'h0, "rd_15");
    access(0, 1'b1, 1'b0, 6'h14, 32'h0, "rd_14");
  endtask

  task automatic test_latency_sweep();
    for (int u = 1; u < 3; u++) begin
      access(u, 1'b0, 1'b1, 6'h2A, 32'hC0DE0000 + 32'(u), "sweep_wr");
      access(u, 1'b1, 1'b0, 6'h2A, 32'h0, "sweep_rd");
      access(u, 1'b1, 1'b0, 6'h00, 32'h0, "sweep_rd0");
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge CLK);
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 6'h08; wd[0] = 32'h12345678;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1; wr[0] = 1'b0;
    #1;
    checks++;
    if (bw[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_busywait: got %b exp 0", bw[0]);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    access(0, 1'b1, 1'b0, 6'h08, 32'h0, "midreset_rd08");
    access(0, 1'b1, 1'b0, 6'h15, 32'h0, "midreset_rd15");
  endtask

  task automatic test_read_write_both();
    access(0, 1'b0, 1'b1, 6'h30, 32'h0BADF00D, "rw_prep_wr");
    access(0, 1'b1, 1'b0, 6'h30, 32'h0, "rw_prep_rd");
    access(0, 1'b1, 1'b1, 6'h02, 32'hA5A5A5A5, "rw_both");
    access(0, 1'b1, 1'b0, 6'h02, 32'h0, "rw_rd02");
  endtask

  task automatic test_back_to_back();
    int n;
    access(0, 1'b0, 1'b1, 6'h21, 32'h11112222, "b2b_wr21");
    access(0, 1'b0, 1'b1, 6'h22, 32'h33334444, "b2b_wr22");
    @(negedge CLK);
    rd[0] = 1'b1; wr[0] = 1'b0; addr[0] = 6'h21;
    last_rd[0] = model_mem[0][6'h21];
    exp_q.push_back(last_rd[0]);
    #1;
    wait_busy(0, n);
    check_done(0, n, "b2b_first");
    addr[0] = 6'h22;
    last_rd[0] = model_mem[0][6'h22];
    exp_q.push_back(last_rd[0]);
    @(negedge CLK);
    #1;
    checks++;
    if (bw[0] !== 1'b1 || st[0] !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle_slot: got bw=%b st=%b exp bw=1 st=00", bw[0], st[0]);
    end
    wait_busy(0, n);
    check_done(0, n, "b2b_second");
    rd[0] = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_random();
    logic [5:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      a = 6'($urandom_range(0, 63));
      d = $urandom;
      access(0, 1'b0, 1'b1, a, d, "rand_wr");
      a = 6'($urandom_range(0, 63));
      access(0, 1'b1, 1'b0, a, 32'h0, "rand_rd");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET  = 1'b1;
    for (int u = 0; u < 3; u++) begin
      rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = 6'h0; wd[u] = 32'h0;
    end
    model_reset();
    test_reset();
    test_write_read();
    test_latency_sweep();
    test_reset_mid_write();
    test_read_write_both();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Block-addressed backing store directly downstream of the data cache: 64 blocks x 32 bits.
- Serves one whole-block read or write per request, with a programmable fixed access latency.
- Signals completion by dropping BUSYWAIT.
- Requester side: the cache controller's MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA drive this block; MEM_READDATA/MEM_BUSYWAIT are driven from it.

Parameters:
- ADDR_W, 6, block address width; depth = 2**ADDR_W.
- BLOCK_W, 32, block (word) width.
- LATENCY, 5, CLK cycles from request acceptance to data commit; legal range 1..255.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- READ  input  1  block read request; held until BUSYWAIT falls.
- WRITE  input  1  block write request; held until BUSYWAIT falls.
- ADDRESS  input  ADDR_W  block address; sampled at acceptance.
- WRITEDATA  input  BLOCK_W  block write data; sampled at acceptance.
- READDATA  output  BLOCK_W  registered read data.
- BUSYWAIT  output  1  high while a request is pending or in progress.

Behaviour:
- Reset is synchronous: RESET sampled high at a rising edge does the following.
  - State goes to IDLE, counter to 0, READDATA to 0.
  - All 64 blocks are cleared to 0.
  - BUSYWAIT is forced 0 while RESET is high.
- Reset mid-operation aborts the access: a pending write is not committed, and the requester must re-issue.
- States:
  - IDLE: no access in progress.
  - BUSY: counting latency.
  - DONE: one-cycle completion slot.
- BUSYWAIT is combinational:
  - IDLE: BUSYWAIT = READ | WRITE, so it rises in the same cycle the request appears, before the requester's next edge.
  - BUSY: 1.
  - DONE: 0.
- IDLE -> BUSY on an edge where READ|WRITE is high.
  - Latch op, ADDRESS and WRITEDATA.
  - Counter loads 1.
- BUSY: counter increments each edge. On the edge where counter == LATENCY, the access executes and state moves to DONE.
  - Read: READDATA <= mem[addr_q].
  - Write: mem[addr_q] <= wdata_q; READDATA unchanged.
- Latency: request accepted at edge k, committed at edge k+LATENCY. BUSYWAIT is low during the cycle after edge k+LATENCY, so the requester sees it low at edge k+LATENCY+1.
- DONE -> IDLE unconditionally.
  - Requests are ignored in DONE.
  - The requester deasserts, or changes to its next op, at edge k+LATENCY+1.
  - A request still high in IDLE is accepted as a new access (back-to-back allowed, one idle cycle minimum between commits).
- READDATA holds its last read value until the next read commit or reset. The requester may sample it any time after BUSYWAIT falls.
- READ and WRITE both high at acceptance: treated as a write; READDATA unchanged.
- Request deasserted or changed during BUSY: ignored; the latched access completes as issued.
- Address wrap: none. ADDRESS is fully decoded and every value is in range.
- X on READ/WRITE in IDLE is a bench error. The RTL must not propagate X into the state register; treat X as 0 via explicit compare to 1.

Decomposition:
- Package data_mem_pkg holds:
  - state encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - default widths ADDR_W/BLOCK_W;
  - LATENCY_MAX=255.
- Sub-module mem_latency_timer: 8-bit up-counter.
  - Inputs: start, clear.
  - Output: expire, asserted when count == LATENCY.
  - Used by the top FSM for the BUSY exit.
- Storage array and FSM stay in the top module.

Test Plan:
- Reset: assert RESET 2 cycles, then read addr 6'h3F -> READDATA 32'h0 after LATENCY edges, BUSYWAIT low 1 cycle.
- Write then read: write 32'hDEADBEEF to 6'h15, then read 6'h15.
  - Each access: BUSYWAIT high exactly LATENCY+1 edges after request.
  - Read returns 32'hDEADBEEF.
  - 6'h14 still reads 0.
- Latency sweep with LATENCY=1 and LATENCY=10: BUSYWAIT high for 2 and 11 sampled edges respectively; READDATA valid when BUSYWAIT falls.
- Reset mid-write: WRITE 32'h12345678 to 6'h08, assert RESET at count 2.
  - BUSYWAIT 0 during reset.
  - Subsequent read of 6'h08 returns 0.
- Simultaneous READ and WRITE to 6'h02 with WRITEDATA 32'hA5A5A5A5.
  - Memory takes the write; READDATA keeps its prior value.
  - Later read returns 32'hA5A5A5A5.
- Back-to-back: hold READ high through DONE with ADDRESS switched to a new block at the falling-BUSYWAIT edge.
  - Second access accepted on the edge after DONE.
  - Both READDATA values correct.
